// File: rtl/p_down_timer_pkg.sv
// -----------------------------------------------------------------------------
// p_down_timer_pkg
// Shared definitions for the loadable down-counter/timer:
//   - state_t     : FSM state encoding (IDLE / RUN / DONE)
//   - DEFAULT_WIDTH : default bit width of the count and reload register
// -----------------------------------------------------------------------------
package p_down_timer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : p_down_timer_pkg

// File: rtl/p_down_timer.sv
// -----------------------------------------------------------------------------
// p_down_timer
// Loadable, programmable down-counter used as an interval / timeout generator.
// A load captures a start value; the count decrements on enabled cycles and
// raises a one-cycle terminal-count pulse when it expires. At expiry it either
// stops (DONE) or reloads the stored start value for a periodic tick.
//
// Ports:
//   clk          in   rising-edge clock
//   clear        in   asynchronous active-high reset of all state
//   load         in   synchronous load strobe (highest priority after clear)
//   load_value   in   WIDTH-bit start / reload value, sampled when load=1
//   enable       in   count enable; decrement only when high
//   auto_reload  in   1: reload at expiry, 0: stop at zero (sampled at expiry)
//   count        out  current count (registered)
//   tc           out  terminal-count pulse, one cycle per expiry (registered)
//   busy         out  high while running (registered)
//   done         out  high while stopped after expiry (registered)
// -----------------------------------------------------------------------------
module p_down_timer
  import p_down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nx;
  logic [WIDTH-1:0] count_nx;
  logic [WIDTH-1:0] reload_reg, reload_nx;
  logic             tc_nx;

  // Next-state / next-count decision
  always_comb begin
    state_nx  = state;
    count_nx  = count;
    reload_nx = reload_reg;
    tc_nx     = 1'b0;

    if (load) begin
      // A load overrides any expiry in the same cycle, so no tc is produced.
      reload_nx = load_value;
      count_nx  = load_value;
      state_nx  = (load_value != ZERO) ? ST_RUN : ST_IDLE;
    end else if (state == ST_RUN && enable) begin
      if (count > ONE) begin
        count_nx = count - ONE;
      end else if (count == ONE) begin
        tc_nx = 1'b1;
        if (auto_reload) begin
          count_nx = reload_reg;
        end else begin
          count_nx = ZERO;
          state_nx = ST_DONE;
        end
      end
      // count==0 cannot occur in RUN (a zero load goes to IDLE); holding
      // here guarantees the count never wraps below zero.
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= ST_IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      reload_reg <= reload_nx;
      tc         <= tc_nx;
      // Status flags are registered from the next state so they line up
      // with the state register rather than lagging it by a cycle.
      busy       <= (state_nx == ST_RUN);
      done       <= (state_nx == ST_DONE);
    end
  end

endmodule : p_down_timer

// File: tb/tb_p_down_timer.sv
// -----------------------------------------------------------------------------
// tb_p_down_timer
// Self-checking bench for p_down_timer. The reference model tracks the timer
// as "period length" plus "enabled cycles elapsed in the current period", and
// derives count/tc/busy/done from those with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_p_down_timer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned m_period;   // start value of the current period
  int unsigned m_elapsed;  // enabled cycles counted in the current period
  bit          m_running;
  bit          m_finished;
  bit          m_tc;

  p_down_timer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .clear       (clear),
    .load        (load),
    .load_value  (load_value),
    .enable      (enable),
    .auto_reload (auto_reload),
    .count       (count),
    .tc          (tc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_period   = 0;
    m_elapsed  = 0;
    m_running  = 0;
    m_finished = 0;
    m_tc       = 0;
  endtask

  // Apply one rising edge to the model using the currently driven inputs.
  task automatic model_edge();
    m_tc = 0;
    if (load) begin
      m_period   = load_value;
      m_elapsed  = 0;
      m_running  = (load_value != 0);
      m_finished = 0;
    end else if (m_running && enable) begin
      m_elapsed++;
      if (m_elapsed == m_period) begin
        m_tc = 1;
        if (auto_reload) begin
          m_elapsed = 0;
        end else begin
          m_running  = 0;
          m_finished = 1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    int unsigned exp_count;
    exp_count = m_running ? (m_period - m_elapsed) : 0;
    check_eq({tag, "_count"}, 32'(count), exp_count);
    check_eq({tag, "_tc"},    32'(tc),    32'(m_tc));
    check_eq({tag, "_busy"},  32'(busy),  32'(m_running));
    check_eq({tag, "_done"},  32'(done),  32'(m_finished));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  // Assert clear between edges; outputs must drop before the next edge.
  task automatic async_clear(input string tag);
    #2;
    clear = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    int pulses;
    int tc_edge;

    clear = 1'b1; load = 1'b0; load_value = '0; enable = 1'b0; auto_reload = 1'b0;
    model_reset();
    #20;
    clear = 1'b0;
    #1;
    check_outputs("t1_reset");

    // 1: enable with nothing loaded keeps count at 0
    enable = 1'b1;
    repeat (10) cycle("t1_idle");

    // 2: one-shot from 5
    load = 1'b1; load_value = 8'd5; auto_reload = 1'b0; enable = 1'b1;
    cycle("t2_load");
    check_eq("t2_load_count", 32'(count), 5);
    load = 1'b0;
    repeat (7) cycle("t2_run");
    check_eq("t2_done_level", 32'(done), 1);

    // 3: auto-reload from 3 for 12 enabled cycles
    load = 1'b1; load_value = 8'd3; auto_reload = 1'b1;
    cycle("t3_load");
    load = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cycle("t3_run");
      if (tc) pulses++;
    end
    check_eq("t3_pulses", pulses, 4);

    // 4: enable toggling, tc after four enabled cycles
    load = 1'b1; load_value = 8'd4; auto_reload = 1'b0; enable = 1'b0;
    cycle("t4_load");
    load = 1'b0;
    tc_edge = -1;
    for (int i = 1; i <= 12; i++) begin
      enable = (i % 2 == 0);
      cycle("t4_run");
      if (tc && tc_edge < 0) tc_edge = i;
    end
    check_eq("t4_tc_edge", tc_edge, 8);

    // 5: async clear mid-run, then zero load
    load = 1'b1; load_value = 8'd10; enable = 1'b1;
    cycle("t5_load");
    load = 1'b0;
    repeat (4) cycle("t5_run");
    check_eq("t5_pre_clear", 32'(count), 6);
    async_clear("t5_clear");
    cycle("t5_after_clear");
    load = 1'b1; load_value = 8'd0;
    cycle("t5_zero_load");
    load = 1'b0;
    repeat (3) cycle("t5_zero_idle");

    // 6: load colliding with expiry, then full-range period
    load = 1'b1; load_value = 8'd2; auto_reload = 1'b1; enable = 1'b1;
    cycle("t6_load");
    load = 1'b0;
    cycle("t6_run");
    load = 1'b1; load_value = 8'd7;
    cycle("t6_collide");
    check_eq("t6_collide_tc", 32'(tc), 0);
    check_eq("t6_collide_count", 32'(count), 7);
    load = 1'b0;
    repeat (3) cycle("t6_after");

    load = 1'b1; load_value = 8'd255; auto_reload = 1'b0;
    cycle("t6_max_load");
    load = 1'b0;
    tc_edge = -1;
    for (int i = 1; i <= 300; i++) begin
      cycle("t6_max_run");
      if (tc && tc_edge < 0) tc_edge = i;
    end
    check_eq("t6_max_tc_edge", tc_edge, 255);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      load        = ($urandom_range(0, 15) == 0);
      load_value  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      enable      = ($urandom_range(0, 3) != 0);
      auto_reload = $urandom_range(0, 1);
      cycle("rnd");
      if ($urandom_range(0, 199) == 0) async_clear("rnd_clear");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_p_down_timer
